uparc_muldiv: RTL and testbench
===============================

Name: uparc_muldiv

Overview:
- Sequential integer multiply/divide unit alongside the single-cycle ALU in the CPU execute stage.
- Executes MIPS-style MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the architectural HI/LO registers. It also handles the MTHI and MTLO writes.
- Pipeline control stalls MFHI/MFLO and any new multiply/divide while busy is high.

Parameters:
- WIDTH, 32: operand and HI/LO width; the only supported value is 32. Iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  synchronous active-low reset
- start  in  1  operation request, sampled each rising edge
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
- rs  in  WIDTH  operand A (multiplicand, dividend, or MTHI/MTLO data)
- rt  in  WIDTH  operand B (multiplier or divisor)
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse when HI/LO receive a mul/div result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: when nrst=0 at a rising edge, the next state is hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
  - Reset overrides start.
  - Reset aborts any in-flight operation; no partial result is written.
- FSM states: IDLE, RUN, FIX.
- Request acceptance:
  - start is accepted only when busy=0.
  - start with busy=1 is ignored entirely, with no queuing.
  - Operands are captured at acceptance; later changes to rs/rt have no effect.
- MTHI/MTLO:
  - Accepted in IDLE; hi (or lo) = rs at the next edge.
  - No busy, no done; FSM stays IDLE.
- op 6/7 with start: no state change.
- Mul/div accept (edge E0):
  - Latch op type.
  - For signed ops, latch |rs| and |rt| as unsigned magnitudes and record the result signs.
  - counter=0, FSM=RUN, busy=1 from the cycle after E0.
- RUN:
  - One shift-add (mul) or one restoring shift-subtract (div) step per cycle.
  - counter increments each step; after WIDTH steps (edge E0+WIDTH), FSM=FIX.
- FIX (one cycle):
  - Apply signs; write hi/lo at edge E0+WIDTH+1.
  - Same edge: busy=0, done=1, FSM=IDLE.
  - done drops at the following edge unless another result completes there.
  - Total latency: start edge to result edge = WIDTH+1 = 33 cycles. busy is high for exactly 33 cycles.
- Multiply result:
  - {hi,lo} = the full 2*WIDTH product.
  - MULT negates the 64-bit magnitude when the operand signs differ.
- Divide result:
  - lo = quotient, hi = remainder.
  - Signed quotient is negative iff the operand signs differ; remainder sign follows the dividend. This is truncation toward zero.
- Divide by zero: no exception, full latency.
  - DIVU: lo=all ones, hi=rs.
  - DIV: lo=all ones if rs>=0, else lo=1; hi=rs. This is the natural restoring result with sign fix.
- DIV overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- hi/lo hold their previous values throughout RUN/FIX; they change only at FIX completion or on MTHI/MTLO.
- Back-to-back: start is accepted in the same cycle done=1, because busy=0 then. A new op accepted there starts at that edge.
- No overflow or trap output; the ALU handles add/sub overflow.

Test Plan:
1. Reset then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIVU rs=100 rt=0 -> after 33 cycles lo=0xFFFFFFFF, hi=100, no other side effects. DIVU rs=100 rt=7 -> lo=14, hi=2.
4. Busy protection:
   - MULTU 3*5 started; at cycle 10 pulse start with MTHI rs=0xDEAD -> ignored; final hi=0, lo=15.
   - Start DIVU 9/2 in the done cycle -> accepted; 33 cycles later lo=4, hi=1.
5. MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive cycles -> hi/lo update on the next edge each; busy and done stay 0.
6. Preload hi=lo=0x55555555 via MTHI/MTLO; start MULT; drive nrst=0 at cycle 15 -> next edge hi=lo=0, busy=0, done=0, no later done pulse. The first op after reset behaves normally.

Source files
------------

// File: rtl/uparc_muldiv.sv
// Iterative MIPS-style multiply/divide unit owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a single sign-fix cycle.
module uparc_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_next;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               signed_op;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               div_fits;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Signed ops iterate on magnitudes; the result signs are re-applied in FIX.
    assign signed_op = ~op[0];
    assign rs_neg    = signed_op & rs[WIDTH-1];
    assign rt_neg    = signed_op & rt[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs : rs;
    assign rt_mag    = rt_neg ? -rt : rt;

    // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign div_fits = rem_sh >= {1'b0, opnd};
    assign div_sub  = rem_sh[WIDTH-1:0] - opnd;

    assign step_acc = !is_div ? {mul_sum, acc[WIDTH-1:1]} :
                      div_fits ? {div_sub, acc[WIDTH-2:0], 1'b1} :
                                 {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    assign prod_fix = neg_q ? -acc : acc;
    assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first, so no path through the case leaves an output unassigned (no latches).
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start && !op[2]) state_next = RUN;
            RUN:     if (counter == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            counter <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'd4:    hi <= rs;
                            3'd5:    lo <= rs;
                            3'd0, 3'd1, 3'd2, 3'd3: counter <= '0;
                            default: ;
                        endcase
                    end
                end
                RUN: counter <= counter + 1'b1;
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: working registers are not reset; every accept reloads them before they are read.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && !op[2]) begin
            is_div <= op[1];
            neg_q  <= rs_neg ^ rt_neg;
            if (op[1]) begin
                opnd  <= rt_mag;
                acc   <= {{WIDTH{1'b0}}, rs_mag};
                neg_r <= rs_neg;
            end else begin
                opnd  <= rs_mag;
                acc   <= {{WIDTH{1'b0}}, rt_mag};
                neg_r <= 1'b0;
            end
        end else if (state == RUN) begin
            acc <= step_acc;
        end
    end

endmodule

// File: tb/tb_uparc_muldiv.sv
// Scoreboard bench for uparc_muldiv: directed scenarios plus randomized mul/div
// checked against a plain-arithmetic reference model.
module tb_uparc_muldiv;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   busy_cnt = 0;

    uparc_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .nrst(nrst), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: {hi, lo} from the architectural definition of each operation.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic   [63:0]   res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (o)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: begin
                if (b == 0) res = {a, (sa < 0) ? 32'd1 : 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Monitor: pops an expectation whenever done is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!nrst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("hi", {32'd0, hi}, {32'd0, e.res[63:32]});
                    check("lo", {32'd0, lo}, {32'd0, e.res[31:0]});
                    check("latency", 64'(cycle - e.cyc), 64'd33);
                    check("busy_cycles", 64'(busy_cnt), 64'd33);
                end
                busy_cnt = 0;
            end
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit accept);
        exp_t e;
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        if (accept && !o[2]) begin
            e.res = model(o, a, b);
            e.cyc = cycle + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        rs    = $urandom;
        rt    = $urandom;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && exp_q.size() == 0) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL wait_idle: timeout after %0d cycles, busy=%0b pending=%0d", budget, busy, exp_q.size());
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        nrst  = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        rs    = '0;
        rt    = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        wait_idle(40);
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1);          wait_idle(40);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);          wait_idle(40);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);  wait_idle(40);
        issue(3'd3, 32'd100, 32'd0, 1);                wait_idle(40);
        issue(3'd3, 32'd100, 32'd7, 1);                wait_idle(40);
        issue(3'd2, 32'hFFFF_FF9C, 32'd0, 1);          wait_idle(40);
        issue(3'd2, 32'd100, 32'hFFFF_FFF9, 1);        wait_idle(40);

        // Start while busy is ignored
        issue(3'd1, 32'd3, 32'd5, 1);
        repeat (8) @(negedge clk);
        check("busy_mid_op", {63'd0, busy}, 64'd1);
        issue(3'd4, 32'h0000_DEAD, 32'd0, 0);
        wait_idle(40);
        check("ignored_mthi_hi", {32'd0, hi}, 64'd0);

        // Start accepted in the done cycle
        issue(3'd3, 32'd20, 32'd3, 1);
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen", {63'd0, done}, 64'd1);
        issue(3'd3, 32'd9, 32'd2, 1);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_idle(40);

        // MTHI then MTLO on consecutive cycles
        issue(3'd4, 32'h1234_5678, 32'd0, 0);
        check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        check("mthi_busy_done", {62'd0, busy, done}, 64'd0);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0, 0);
        check("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
        check("mtlo_hi_kept", {32'd0, hi}, 64'h1234_5678);
        check("mtlo_busy_done", {62'd0, busy, done}, 64'd0);

        // No-op codes
        issue(3'd6, 32'hAAAA_AAAA, 32'd1, 0);
        issue(3'd7, 32'hBBBB_BBBB, 32'd1, 0);
        check("noop_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        check("noop_busy", {63'd0, busy}, 64'd0);

        // Reset aborts an in-flight MULT
        issue(3'd4, 32'h5555_5555, 32'd0, 0);
        issue(3'd5, 32'h5555_5555, 32'd0, 0);
        check("preload", {hi, lo}, 64'h5555_5555_5555_5555);
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1);
        repeat (13) @(negedge clk);
        nrst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        nrst = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_hilo_later", {hi, lo}, 64'd0);
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1);
        wait_idle(40);

        // Randomized mul/div with corner-biased operands
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            issue(o, a, b, 1);
            wait_idle(40);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
